mem_lane_aligner: RTL and testbench
===================================

// Module: mem_lane_aligner
// PURPOSE
//  Byte-lane steering between a 32-bit word-organised RAM and a byte-addressed
//  load/store port. Write side (combinational): byte strobes and lane-shifted data
//  from size code + address offset. Read side: size/offset latched at read
//  issue, applied to the RAM word returned one cycle later (synchronous-read RAM).
//  Sits between the core LSU and the memory array.
// PARAMETERS
//  MASK_MISALIGNED  1  1: misaligned write forces w_strb=0; 0: strobes truncated to word
//  ZERO_ON_ERR      1  1: misaligned/illegal read returns 32'h0; 0: returns shifted bytes
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   synchronous reset, active-high
//  w_bmul       in   2   write size: 0->1 byte, 1->2 bytes, 2->4 bytes, 3 illegal
//  w_boff       in   2   write byte offset (addr[1:0])
//  w_data       in   32  store data, right-justified
//  w_strb       out  4   byte-lane write enables, bit i = bits [8i+7:8i]
//  w_data_align out  32  store data shifted into lanes
//  w_err        out  1   combinational: illegal size or misaligned write
//  r_en         in   1   read issued this cycle (RAM word valid next cycle)
//  r_bmul       in   2   read size, same encoding as w_bmul
//  r_aoff       in   2   read byte offset
//  r_word       in   32  raw RAM word (valid cycle after r_en)
//  r_data       out  32  zero-extended, right-justified load data
//  r_err        out  1   registered: latched read was illegal/misaligned
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-high (clk, rst).
//  Write path (pure combinational, no state):
//   - base mask: bmul0=4'b0001, bmul1=4'b0011, bmul2=4'b1111, bmul3=4'b0000.
//   - w_strb = (base << w_boff) truncated to 4 bits.
//   - w_data_align = (w_data << 8*w_boff) truncated to 32 bits; bytes of
//     w_data beyond size are don't-care for RAM (strobes gate them).
//   - misaligned: bmul1 with boff[0]=1, or bmul2 with boff!=0.
//   - w_err = misaligned | (w_bmul==3). If MASK_MISALIGNED=1 and w_err, w_strb=0.
//  Read path (1-cycle latency, matches sync RAM):
//   - on clk edge with r_en=1: latch r_bmul->q_bmul, r_aoff->q_aoff,
//     r_err <= misaligned|illegal. With r_en=0 latched values held.
//   - r_data (comb from latches + r_word): s = r_word >> 8*q_aoff;
//     bmul0 -> {24'h0,s[7:0]}, bmul1 -> {16'h0,s[15:0]}, bmul2 -> s, bmul3 -> 0.
//   - if ZERO_ON_ERR=1 and r_err: r_data=32'h0.
//   - back-to-back reads: each r_en overwrites latches; data for read N is
//     valid exactly in the cycle after read N is issued.
//  Reset: q_bmul<=2 (word), q_aoff<=0, r_err<=0, so r_data=r_word after reset.
//   Reset takes priority over r_en in the same edge. Write path unaffected by rst.
//  Simultaneous read and write in one cycle are independent here (arbitration
//  is the memory's job).
// TESTING
//  1 w_bmul=0,w_boff=2,w_data=32'h000000AB -> w_strb=4'b0100, w_data_align=32'h00AB0000, w_err=0.
//  2 w_bmul=1,w_boff=2,w_data=32'h0000BEEF -> w_strb=4'b1100, align=32'hBEEF0000;
//    w_boff=1 -> w_err=1, w_strb=0 (MASK_MISALIGNED=1).
//  3 w_bmul=2,w_boff=0,w_data=32'hDEADBEEF -> w_strb=4'hF, align=32'hDEADBEEF; w_bmul=3 -> w_err=1.
//  4 r_en=1,r_bmul=0,r_aoff=3; next cycle r_word=32'h12345678 -> r_data=32'h00000012, r_err=0;
//    r_bmul=1,r_aoff=2 -> 32'h00001234.
//  5 r_en with r_bmul=2,r_aoff=1 -> next cycle r_err=1, r_data=0; then rst=1 -> r_err=0,
//    r_data=r_word.
//  6 reads every cycle with alternating size/offset -> each result uses its own
//    issue-cycle size/offset; r_en=0 holds last interpretation.

Source files
------------

// File: rtl/mem_lane_aligner_if.sv
// Load/store byte-lane bus between the LSU (master) and the lane aligner (slave).
interface mem_lane_aligner_if;
  logic [1:0]  w_bmul;
  logic [1:0]  w_boff;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic [31:0] w_data_align;
  logic        w_err;
  logic        r_en;
  logic [1:0]  r_bmul;
  logic [1:0]  r_aoff;
  logic [31:0] r_word;
  logic [31:0] r_data;
  logic        r_err;

  modport master (
    output w_bmul, w_boff, w_data, r_en, r_bmul, r_aoff, r_word,
    input  w_strb, w_data_align, w_err, r_data, r_err
  );

  modport slave (
    input  w_bmul, w_boff, w_data, r_en, r_bmul, r_aoff, r_word,
    output w_strb, w_data_align, w_err, r_data, r_err
  );
endinterface

// File: rtl/mem_lane_aligner.sv
// Byte-lane steering between a 32-bit word RAM and a byte-addressed LSU port.
// Writes are purely combinational; reads latch size/offset at issue and apply
// them to the RAM word that comes back one cycle later.
module mem_lane_aligner #(
  parameter bit MASK_MISALIGNED = 1'b1,
  parameter bit ZERO_ON_ERR     = 1'b1
) (
  input logic             clk,
  input logic             rst,
  mem_lane_aligner_if.slave bus
);
  localparam int NUM_LANES = 4;

  // Illegal size or an access that straddles its natural alignment.
  function automatic logic is_bad(input logic [1:0] bmul, input logic [1:0] off);
    return (bmul == 2'd3) || ((bmul == 2'd1) && off[0]) || ((bmul == 2'd2) && (off != 2'd0));
  endfunction

  // Unshifted strobe pattern for a size code.
  function automatic logic [NUM_LANES-1:0] base_mask(input logic [1:0] bmul);
    case (bmul)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      2'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  logic [1:0]                 q_bmul;
  logic [1:0]                 q_aoff;
  logic                       q_err;
  logic                       w_bad;
  logic [NUM_LANES-1:0]       strb_sh;
  logic [NUM_LANES-1:0][7:0]  word_b;
  logic [NUM_LANES-1:0][7:0]  shift_b;
  logic [31:0]                shift_w;

  // Write path: strobes and lane-shifted store data, no state.
  always_comb begin
    w_bad            = is_bad(bus.w_bmul, bus.w_boff);
    strb_sh          = base_mask(bus.w_bmul) << bus.w_boff;
    bus.w_err        = w_bad;
    bus.w_strb       = (MASK_MISALIGNED && w_bad) ? '0 : strb_sh;
    bus.w_data_align = bus.w_data << {bus.w_boff, 3'b000};
  end

  // Read attributes captured at issue; reset selects a plain word read.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_bmul <= 2'd2;
      q_aoff <= 2'd0;
      q_err  <= 1'b0;
    end else if (bus.r_en) begin
      q_bmul <= bus.r_bmul;
      q_aoff <= bus.r_aoff;
      q_err  <= is_bad(bus.r_bmul, bus.r_aoff);
    end
  end

  assign word_b = bus.r_word;

  // Each output lane pulls the RAM byte q_aoff lanes above it (zero past the top).
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    always_comb begin
      shift_b[i] = 8'h00;
      if ((i + int'(q_aoff)) < NUM_LANES)
        shift_b[i] = word_b[i + int'(q_aoff)];
    end
  end

  assign shift_w = shift_b;

  // Size masking / zero extension of the right-justified load data.
  always_comb begin
    case (q_bmul)
      2'd0:    bus.r_data = {24'h0, shift_w[7:0]};
      2'd1:    bus.r_data = {16'h0, shift_w[15:0]};
      2'd2:    bus.r_data = shift_w;
      default: bus.r_data = 32'h0;
    endcase
    if (ZERO_ON_ERR && q_err)
      bus.r_data = 32'h0;
    bus.r_err = q_err;
  end
endmodule

// File: tb/tb_mem_lane_aligner.sv
// Bench for mem_lane_aligner: write-path vector table, hand-written read
// sequences, then random traffic against an arithmetic reference model.
module tb_mem_lane_aligner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_lane_aligner_if bus();

  mem_lane_aligner dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  bmul;
    logic [1:0]  boff;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] align;
    logic        err;
  } wvec_t;

  wvec_t wtab[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: sizes as byte counts, alignment as a modulus.
  function automatic logic m_err(input logic [1:0] bmul, input logic [1:0] off);
    int n = 1 << bmul;
    return (bmul == 2'd3) || ((int'(off) % n) != 0);
  endfunction

  function automatic logic [3:0] m_strb(input logic [1:0] bmul, input logic [1:0] off);
    int n = 1 << bmul;
    int m;
    if (m_err(bmul, off)) return 4'h0;
    m = ((1 << n) - 1) << off;
    return 4'(m & 15);
  endfunction

  function automatic logic [31:0] m_align(input logic [31:0] d, input logic [1:0] off);
    longint v = longint'(d) << (8 * int'(off));
    return 32'(v & 64'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] bmul, input logic [1:0] off,
                                          input logic [31:0] w);
    longint v;
    int n = 1 << bmul;
    if (m_err(bmul, off)) return 32'h0;
    v = longint'(w) >> (8 * int'(off));
    return 32'(v & ((64'd1 << (8 * n)) - 1));
  endfunction

  // Issue a read this cycle (latched on the next edge).
  task automatic issue(input logic [1:0] bmul, input logic [1:0] off);
    @(posedge clk); #1;
    bus.r_en = 1'b1; bus.r_bmul = bmul; bus.r_aoff = off;
  endtask

  // Present the RAM word in the cycle after issue and check the result.
  task automatic ret(input string name, input logic [31:0] word,
                     input logic [31:0] exp_d, input logic exp_e);
    @(posedge clk); #1;
    bus.r_en = 1'b0; bus.r_word = word;
    #3;
    chk({name, "_data"}, bus.r_data, exp_d);
    chk({name, "_err"}, {31'h0, bus.r_err}, {31'h0, exp_e});
  endtask

  logic [1:0]  mq_bmul, mq_aoff;
  logic [31:0] exp_r;

  initial begin
    wtab[0] = '{2'd0, 2'd2, 32'h000000AB, 4'b0100, 32'h00AB0000, 1'b0};
    wtab[1] = '{2'd1, 2'd2, 32'h0000BEEF, 4'b1100, 32'hBEEF0000, 1'b0};
    wtab[2] = '{2'd1, 2'd1, 32'h0000BEEF, 4'b0000, 32'h00BEEF00, 1'b1};
    wtab[3] = '{2'd2, 2'd0, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 1'b0};
    wtab[4] = '{2'd3, 2'd0, 32'hDEADBEEF, 4'b0000, 32'hDEADBEEF, 1'b1};
    wtab[5] = '{2'd0, 2'd3, 32'h00000012, 4'b1000, 32'h12000000, 1'b0};
    wtab[6] = '{2'd1, 2'd0, 32'h00001234, 4'b0011, 32'h00001234, 1'b0};
    wtab[7] = '{2'd2, 2'd2, 32'hDEADBEEF, 4'b0000, 32'hBEEF0000, 1'b1};
    wtab[8] = '{2'd0, 2'd1, 32'h0000005A, 4'b0010, 32'h00005A00, 1'b0};
    wtab[9] = '{2'd1, 2'd3, 32'h0000FFFF, 4'b0000, 32'hFF000000, 1'b1};

    bus.w_bmul = 2'd0; bus.w_boff = 2'd0; bus.w_data = 32'h0;
    bus.r_en = 1'b0; bus.r_bmul = 2'd0; bus.r_aoff = 2'd0; bus.r_word = 32'h0;

    // Reset state: word read at offset 0, no error.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; bus.r_word = 32'hCAFEF00D;
    #3;
    chk("rst_data", bus.r_data, 32'hCAFEF00D);
    chk("rst_err", {31'h0, bus.r_err}, 32'h0);

    // Write path table.
    for (int i = 0; i < 10; i++) begin
      bus.w_bmul = wtab[i].bmul; bus.w_boff = wtab[i].boff; bus.w_data = wtab[i].data;
      #1;
      chk($sformatf("w%0d_strb", i), {28'h0, bus.w_strb}, {28'h0, wtab[i].strb});
      chk($sformatf("w%0d_align", i), bus.w_data_align, wtab[i].align);
      chk($sformatf("w%0d_err", i), {31'h0, bus.w_err}, {31'h0, wtab[i].err});
    end

    // Byte and halfword loads from the upper lanes.
    issue(2'd0, 2'd3); ret("rd_b3", 32'h12345678, 32'h00000012, 1'b0);
    issue(2'd1, 2'd2); ret("rd_h2", 32'h12345678, 32'h00001234, 1'b0);
    // r_en low: previous interpretation held with a new word.
    ret("rd_hold", 32'hA5A55A5A, 32'h0000A5A5, 1'b0);
    // Misaligned word read zeroes data, then reset clears the error.
    issue(2'd2, 2'd1); ret("rd_mis", 32'h12345678, 32'h0, 1'b1);
    @(posedge clk); #1; rst = 1'b1; bus.r_en = 1'b1; bus.r_bmul = 2'd3; bus.r_aoff = 2'd3;
    @(posedge clk); #1; rst = 1'b0; bus.r_en = 1'b0; bus.r_word = 32'h87654321;
    #3;
    chk("rd_rst_data", bus.r_data, 32'h87654321);
    chk("rd_rst_err", {31'h0, bus.r_err}, 32'h0);
    // Back-to-back reads, each result tied to its own issue cycle.
    issue(2'd0, 2'd1);
    @(posedge clk); #1; bus.r_word = 32'h11223344; bus.r_bmul = 2'd1; bus.r_aoff = 2'd0;
    #3; chk("b2b_0", bus.r_data, 32'h00000033);
    @(posedge clk); #1; bus.r_word = 32'h55667788; bus.r_bmul = 2'd2; bus.r_aoff = 2'd0;
    #3; chk("b2b_1", bus.r_data, 32'h00007788);
    ret("b2b_2", 32'h99AABBCC, 32'h99AABBCC, 1'b0);

    // Random traffic against the model; starts from a known reset state.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    mq_bmul = 2'd2; mq_aoff = 2'd0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      rst         = ($urandom_range(0, 31) == 0);
      bus.r_en    = ($urandom_range(0, 3) != 0);
      bus.r_bmul  = 2'($urandom_range(0, 3));
      bus.r_aoff  = 2'($urandom_range(0, 3));
      bus.r_word  = $urandom;
      bus.w_bmul  = 2'($urandom_range(0, 3));
      bus.w_boff  = 2'($urandom_range(0, 3));
      bus.w_data  = $urandom;
      #3;
      exp_r = m_rdata(mq_bmul, mq_aoff, bus.r_word);
      chk("rnd_rdata", bus.r_data, exp_r);
      chk("rnd_rerr", {31'h0, bus.r_err}, {31'h0, m_err(mq_bmul, mq_aoff)});
      chk("rnd_strb", {28'h0, bus.w_strb}, {28'h0, m_strb(bus.w_bmul, bus.w_boff)});
      chk("rnd_align", bus.w_data_align, m_align(bus.w_data, bus.w_boff));
      chk("rnd_werr", {31'h0, bus.w_err}, {31'h0, m_err(bus.w_bmul, bus.w_boff)});
      if (rst) begin
        mq_bmul = 2'd2; mq_aoff = 2'd0;
      end else if (bus.r_en) begin
        mq_bmul = bus.r_bmul; mq_aoff = bus.r_aoff;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
